// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the folded encrypt core.
//   - FSM state encoding for aes_encrypt_iter.
//   - Round count and round-key bus width.
//   - Forward S-box table plus SubBytes/xtime/MixColumns helpers.
//   - Byte order: byte i of a 128-bit block (i = 0..15, FIPS-197
//     input order) occupies bits [120-8*i +: 8]. Byte 0 is the MSB.
//     The state is column-major: byte i sits at row i%4, column i/4.
package aes_pkg;

  localparam int unsigned ROUNDS = 10;
  localparam int unsigned RK_W   = 128 * (ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_state_t;

  // Forward S-box; entry 0 in the top byte, entry 255 in the bottom byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Bit offset of byte i within a 128-bit block.
  function automatic int unsigned byte_lsb(input int unsigned i);
    return 120 - 8 * i;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8 * (255 - int'(b)) +: 8];
  endfunction

  // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES-128 encryption round, purely combinational.
//   state_in    : round input state (aes_pkg byte order)
//   round_key   : key added at the end of this round
//   final_round : 1 for round 10, which skips MixColumns
//   state_out   : round result
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [127:0] sub_state;
  logic [127:0] shift_state;
  logic [127:0] mix_state;

  always_comb begin
    sub_state = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sub_state[byte_lsb(i) +: 8] = sbox(state_in[byte_lsb(i) +: 8]);
    end
  end

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  always_comb begin
    shift_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shift_state[byte_lsb(4 * c + r) +: 8] =
          sub_state[byte_lsb(4 * ((c + r) % 4) + r) +: 8];
      end
    end
  end

  always_comb begin
    mix_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mix_state[96 - 32 * c +: 32] = mix_column(shift_state[96 - 32 * c +: 32]);
    end
  end

  always_comb begin
    state_out = (final_round ? shift_state : mix_state) ^ round_key;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Folded AES-128 encryption core, UNROLL rounds per clock.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : block input handshake
//   in_data, in_tag       : plaintext and pass-through tag
//   round_keys            : 11 expanded keys, key i at [128*i +: 128]
//   out_valid/out_ready   : ciphertext output handshake
//   out_data, out_tag     : ciphertext and the tag of its block
// A block takes 10/UNROLL cycles in RUN; the result is held in DONE
// until out_ready, and a new block may be accepted on that same edge.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [RK_W-1:0]   round_keys,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic [TAG_W-1:0]  out_tag
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_encrypt_iter: UNROLL must be 1, 2, 5 or 10");
  end
  if (TAG_W == 0) begin : g_bad_tag
    $error("aes_encrypt_iter: TAG_W must be at least 1");
  end

  // Value of rnd during the cycle that computes round 10.
  localparam logic [3:0] LAST_RND = 4'(ROUNDS + 1 - UNROLL);
  localparam logic [3:0] STEP     = 4'(UNROLL);

  aes_state_t       state;
  logic [3:0]       rnd;
  logic [127:0]     state_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [127:0]     key_reg [ROUNDS+1];
  logic             accept;
  logic [127:0]     round_out;

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    end
    accept = in_valid && in_ready;
  end

  // Round chain: stage g computes absolute round rnd+g.
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [4:0]   ridx;
    logic         last;
    logic [127:0] rkey;
    logic [127:0] sin;
    logic [127:0] sout;

    always_comb begin
      ridx = 5'(rnd) + 5'(g);
      last = (ridx == 5'(ROUNDS));
      rkey = key_reg[ROUNDS];
      if (ridx <= 5'(ROUNDS)) begin
        rkey = key_reg[ridx[3:0]];
      end
    end

    if (g == 0) begin : g_first
      always_comb sin = state_reg;
    end else begin : g_next
      always_comb sin = g_round[g-1].sout;
    end

    aes_round_comb u_round (
      .state_in    (sin),
      .round_key   (rkey),
      .final_round (last),
      .state_out   (sout)
    );
  end

  always_comb round_out = g_round[UNROLL-1].sout;

  // Keys are only ever read during RUN, after a load, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i <= ROUNDS; i++) begin
        key_reg[i] <= round_keys[128 * i +: 128];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
      tag_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          state_reg <= round_out;
          rnd       <= rnd + STEP;
          if (rnd == LAST_RND) begin
            out_data  <= round_out;
            out_tag   <= tag_reg;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // accept is only possible in IDLE or in DONE with out_ready, so this
      // load overrides the IDLE return above for the back-to-back case.
      if (accept) begin
        state_reg <= in_data ^ round_keys[127:0];
        tag_reg   <= in_tag;
        rnd       <= 4'd1;
        state     <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: one instance per legal UNROLL
// (1, 2, 5, 10), checked against an S-box/GF(2^8) reference model and
// FIPS-197 known answers.
module tb_aes_encrypt_iter;

  localparam int NDUT = 4;

  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NDUT-1:0]   in_valid, in_ready, out_valid, out_ready;
  logic [127:0]      in_data;
  logic [7:0]        in_tag;
  logic [1407:0]     round_keys;
  logic [127:0]      out_data [NDUT];
  logic [7:0]        out_tag  [NDUT];

  int total = 0;
  int bad   = 0;
  int edges = 0;
  logic [7:0] sb [256];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    aes_encrypt_iter #(
      .UNROLL ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10),
      .TAG_W  (8)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data),
      .in_tag     (in_tag),
      .round_keys (round_keys),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .out_tag    (out_tag[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  function automatic int unroll_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 5 : 10;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] rk;
    for (int i = 0; i < 4; i++) w[i] = key[96 - 32 * i +: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[128 * r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1407:0] rk);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k;
    logic [127:0] res;
    k = rk[127:0];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[120 - 8 * (4 * c + r) +: 8] ^ k[120 - 8 * (4 * c + r) +: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sb[s[r][(c + r) % 4]];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[1][c] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[2][c] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[3][c] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      k = rk[128 * rnd +: 128];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[120 - 8 * (4 * c + r) +: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[120 - 8 * (4 * c + r) +: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic run_block(input int d, input logic [127:0] pt, input logic [127:0] key,
                           input logic [7:0] tag, input logic [127:0] known, input bit has_known);
    logic [1407:0] rk;
    logic [127:0]  exp;
    int            n;
    rk  = expand_key(key);
    exp = model_encrypt(pt, rk);
    in_data = pt; in_tag = tag; round_keys = rk;
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b1;
    #1;
    n = 0;
    while (!in_ready[d] && n < 50) begin tick(); n++; end
    check($sformatf("accept_ready_u%0d", unroll_of(d)), 128'(in_ready[d]), 128'(1'b1));
    tick();
    in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 40) begin tick(); n++; end
    check($sformatf("latency_u%0d", unroll_of(d)), 128'(n), 128'(10 / unroll_of(d)));
    check($sformatf("data_model_u%0d", unroll_of(d)), out_data[d], exp);
    if (has_known) check($sformatf("data_fips_u%0d", unroll_of(d)), out_data[d], known);
    check($sformatf("tag_u%0d", unroll_of(d)), 128'(out_tag[d]), 128'(tag));
    out_ready[d] = 1'b1;
    tick();
    check($sformatf("drain_u%0d", unroll_of(d)), 128'(out_valid[d]), 128'(1'b0));
    out_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1407:0] rk_b, rk_c, rk_s;
    logic [127:0]  pts [16];
    logic [127:0]  exp_q [$];
    int            acc_q [$];
    int            n, sent, got, guard, rises;
    bit            acc;

    rst_n = 1'b0;
    in_valid = '0; out_ready = '0;
    in_data = '0; in_tag = '0; round_keys = '0;
    build_sbox();
    rk_b = expand_key(B_KEY);
    rk_c = expand_key(C_KEY);

    // Reset state
    tick(); tick();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_in_ready_u%0d", unroll_of(d)), 128'(in_ready[d]), 128'(1'b0));
      check($sformatf("rst_out_valid_u%0d", unroll_of(d)), 128'(out_valid[d]), 128'(1'b0));
      check($sformatf("rst_out_data_u%0d", unroll_of(d)), out_data[d], 128'h0);
      check($sformatf("rst_out_tag_u%0d", unroll_of(d)), 128'(out_tag[d]), 128'h0);
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("idle_in_ready_u%0d", unroll_of(d)), 128'(in_ready[d]), 128'(1'b1));
    tick();

    // Known answers: App. B on UNROLL=1, App. C.1 on 2/5/10
    run_block(0, B_PT, B_KEY, 8'h5A, B_CT, 1'b1);
    for (int d = 1; d < NDUT; d++) run_block(d, C_PT, C_KEY, 8'hC1, C_CT, 1'b1);

    // Random blocks on every width
    for (int d = 0; d < NDUT; d++)
      for (int k = 0; k < 3; k++)
        run_block(d, rand128(), rand128(), 8'($urandom()), 128'h0, 1'b0);

    // Backpressure with simultaneous complete/accept (UNROLL=1)
    in_data = C_PT; round_keys = rk_c; in_tag = 8'hC1;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 40) begin tick(); n++; end
    check("bp_latency", 128'(n), 128'd10);
    in_data = B_PT; round_keys = rk_b; in_tag = 8'h5A; in_valid[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("bp_valid_hold", 128'(out_valid[0]), 128'(1'b1));
      check("bp_data_hold", out_data[0], C_CT);
      check("bp_tag_hold", 128'(out_tag[0]), 128'hC1);
      check("bp_in_ready_low", 128'(in_ready[0]), 128'(1'b0));
      tick();
    end
    out_ready[0] = 1'b1;
    #1;
    check("bp_in_ready_release", 128'(in_ready[0]), 128'(1'b1));
    tick();
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    check("bp_handoff_valid", 128'(out_valid[0]), 128'(1'b0));
    n = 0;
    while (!out_valid[0] && n < 40) begin tick(); n++; end
    check("bp_b_latency", 128'(n), 128'd10);
    check("bp_b_data", out_data[0], B_CT);
    check("bp_b_tag", 128'(out_tag[0]), 128'h5A);
    out_ready[0] = 1'b1; tick(); out_ready[0] = 1'b0;

    // Busy-input isolation (UNROLL=1)
    in_data = C_PT; round_keys = rk_c; in_tag = 8'hC1; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 40) begin
      in_data = rand128(); in_tag = 8'($urandom());
      for (int w = 0; w < 44; w++) round_keys[32 * w +: 32] = $urandom();
      tick(); n++;
    end
    for (int i = 0; i < 3; i++) begin
      in_data = rand128(); in_tag = 8'($urandom());
      for (int w = 0; w < 44; w++) round_keys[32 * w +: 32] = $urandom();
      tick();
    end
    check("iso_latency", 128'(n), 128'd10);
    check("iso_data", out_data[0], C_CT);
    check("iso_tag", 128'(out_tag[0]), 128'hC1);
    out_ready[0] = 1'b1; tick(); out_ready[0] = 1'b0;

    // Reset mid-operation at rnd=4 (UNROLL=1); out_data currently holds C_CT
    in_data = C_PT; round_keys = rk_c; in_tag = 8'hC1; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'(1'b0));
    tick();
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(1'b0));
    check("mid_rst_out_data", out_data[0], 128'h0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_in_ready_after", 128'(in_ready[0]), 128'(1'b1));
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid[0]) rises++;
    end
    check("mid_rst_no_output", 128'(rises), 128'd0);

    // Streaming 16 blocks, UNROLL=10, out_ready held high
    rk_s = expand_key(rand128());
    for (int i = 0; i < 16; i++) pts[i] = rand128();
    out_ready[3] = 1'b1;
    sent = 0; got = 0; guard = 0;
    while ((sent < 16 || got < 16) && guard < 200) begin
      if (out_valid[3]) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_output", 128'(out_valid[3]), 128'(1'b0));
        end else begin
          check("stream_data", out_data[3], exp_q.pop_front());
          check("stream_tag_order", 128'(out_tag[3]), 128'(got));
          check("stream_latency", 128'(edges - acc_q.pop_front()), 128'd1);
          got++;
        end
      end
      if (sent < 16) begin
        in_valid[3] = 1'b1; in_data = pts[sent]; in_tag = 8'(sent); round_keys = rk_s;
      end else begin
        in_valid[3] = 1'b0;
      end
      #1;
      acc = in_valid[3] && in_ready[3];
      tick();
      guard++;
      if (acc) begin
        exp_q.push_back(model_encrypt(pts[sent], rk_s));
        acc_q.push_back(edges);
        sent++;
      end
    end
    check("stream_count", 128'(got), 128'd16);
    in_valid[3] = 1'b0; out_ready[3] = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
